// File: rtl/fxp_pkg.sv
// Shared types and defaults for the sequential fixed-point multiplier.
// Holds the FSM state encoding and the default operand format.
package fxp_pkg;

    localparam int DEF_INT_W  = 8;
    localparam int DEF_FRAC_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fxp_shift_add_dp.sv
// Shift-add datapath: one multiplier bit per step, W steps per product.
// Exposes the next accumulator value so the product can be taken on the last step.
module fxp_shift_add_dp #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           step,
    input  logic [W-1:0]   mcand_in,
    input  logic [W-1:0]   mplr_in,
    output logic [2*W-1:0] acc_nxt,
    output logic           last
);

    localparam int CW = $clog2(W) + 1;

    logic [W-1:0]   mcand;
    logic [W-1:0]   mplr;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [W:0]     sum;

    // Carry out of the upper-half add lands in the top bit after the shift.
    always_comb begin
        sum     = {1'b0, acc[2*W-1:W]} + (mplr[0] ? {1'b0, mcand} : '0);
        acc_nxt = {sum, acc[W-1:1]};
        last    = (cnt == CW'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (start) begin
            mcand <= mcand_in;
            mplr  <= mplr_in;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            acc   <= acc_nxt;
            mplr  <= mplr >> 1;
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fxp_mul_seq.sv
// Sequential INT_W.FRAC_W fixed-point multiplier with result handshake.
// Define FXP_MUL_SIGNED_EN for two's-complement operands and result.
module fxp_mul_seq
    import fxp_pkg::*;
#(
    parameter int INT_W  = DEF_INT_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INT_W-1:0]    a_int,
    input  logic [FRAC_W-1:0]   a_dec,
    input  logic [INT_W-1:0]    b_int,
    input  logic [FRAC_W-1:0]   b_dec,
    input  logic                in_rdy,
    output logic                busy,
    output logic [2*INT_W-1:0]  res_int,
    output logic [2*FRAC_W-1:0] res_dec,
    output logic                res_rdy,
    input  logic                res_ack
);

    localparam int W = INT_W + FRAC_W;

    state_t         state;
    logic [W-1:0]   a_raw;
    logic [W-1:0]   b_raw;
    logic [W-1:0]   a_op;
    logic [W-1:0]   b_op;
    logic [2*W-1:0] acc_nxt;
    logic [2*W-1:0] prod;
    logic           dp_last;
    logic           start;
    logic           step;

    assign a_raw = {a_int, a_dec};
    assign b_raw = {b_int, b_dec};
    assign start = (state == IDLE) && in_rdy;
    assign step  = (state == MUL);

`ifdef FXP_MUL_SIGNED_EN
    logic neg_q;

    // Magnitudes go through the unsigned core; sign is reapplied at the end.
    always_comb begin
        a_op = a_raw[W-1] ? -a_raw : a_raw;
        b_op = b_raw[W-1] ? -b_raw : b_raw;
        prod = neg_q ? -acc_nxt : acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else if (start) begin
            neg_q <= a_raw[W-1] ^ b_raw[W-1];
        end
    end
`else
    assign a_op = a_raw;
    assign b_op = b_raw;
    assign prod = acc_nxt;
`endif

    fxp_shift_add_dp #(
        .W(W)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .step     (step),
        .mcand_in (a_op),
        .mplr_in  (b_op),
        .acc_nxt  (acc_nxt),
        .last     (dp_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            res_rdy <= 1'b0;
            res_int <= '0;
            res_dec <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_rdy) begin
                        state <= MUL;
                        busy  <= 1'b1;
                    end
                end
                MUL: begin
                    if (dp_last) begin
                        res_int <= prod[2*W-1:2*FRAC_W];
                        res_dec <= prod[2*FRAC_W-1:0];
                        res_rdy <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (res_ack) begin
                        res_rdy <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_mul_seq.sv
// Directed self-checking bench for fxp_mul_seq at the default 8.8 format.
// Define FXP_MUL_SIGNED_EN to exercise the two's-complement build.
module tb_fxp_mul_seq;

    localparam int W = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  a_int;
    logic [7:0]  a_dec;
    logic [7:0]  b_int;
    logic [7:0]  b_dec;
    logic        in_rdy;
    logic        busy;
    logic [15:0] res_int;
    logic [15:0] res_dec;
    logic        res_rdy;
    logic        res_ack;
    logic [31:0] res;

    int n_cmp;
    int n_bad;

    assign res = {res_int, res_dec};

    fxp_mul_seq #(
        .INT_W  (8),
        .FRAC_W (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_int   (a_int),
        .a_dec   (a_dec),
        .b_int   (b_int),
        .b_dec   (b_dec),
        .in_rdy  (in_rdy),
        .busy    (busy),
        .res_int (res_int),
        .res_dec (res_dec),
        .res_rdy (res_rdy),
        .res_ack (res_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept(input string tag, input logic [15:0] a, input logic [15:0] b);
        {a_int, a_dec} = a;
        {b_int, b_dec} = b;
        in_rdy = 1'b1;
        tick();
        check({tag, "_acc_busy"}, {31'd0, busy}, 32'd1);
        {a_int, a_dec} = 16'hA55A;
        {b_int, b_dec} = 16'h3CC3;
    endtask

    // mode 0: in_rdy low; 1: in_rdy held; 2: in_rdy/res_ack toggling
    task automatic wait_res(input string tag, input int mode, input logic [31:0] exp);
        int lat;
        int bc;
        lat = 0;
        bc  = 0;
        if (mode == 0) in_rdy = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (busy) bc++;
            if (res_rdy) begin
                lat = i;
                break;
            end
            if (mode == 2) begin
                in_rdy  = i[0];
                res_ack = ~i[0];
            end
        end
        in_rdy  = 1'b0;
        res_ack = 1'b0;
        check({tag, "_lat"}, lat, W);
        check({tag, "_busy"}, bc, W);
        check({tag, "_res"}, res, exp);
    endtask

    task automatic ack(input string tag, input logic [31:0] exp);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check({tag, "_ack_rdy"}, {31'd0, res_rdy}, 32'd0);
        check({tag, "_ack_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_ack_hold"}, res, exp);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        in_rdy  = 1'b0;
        res_ack = 1'b0;
        a_int   = '0;
        a_dec   = '0;
        b_int   = '0;
        b_dec   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_rdy", {31'd0, res_rdy}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res", res, 32'd0);

        accept("t1", 16'h0200, 16'h0200);
        wait_res("t1", 1, 32'h0004_0000);
        ack("t1", 32'h0004_0000);

        accept("t2", 16'h0180, 16'h0240);
        wait_res("t2", 0, 32'h0003_6000);
        for (int k = 0; k < 10; k++) begin
            in_rdy = k[0];
            tick();
            check("t2_hold_rdy", {31'd0, res_rdy}, 32'd1);
            check("t2_hold_res", res, 32'h0003_6000);
        end
        in_rdy = 1'b0;
        ack("t2", 32'h0003_6000);

        accept("t3", 16'hFFFF, 16'hFFFF);
`ifdef FXP_MUL_SIGNED_EN
        wait_res("t3", 2, 32'h0000_0001);
        ack("t3", 32'h0000_0001);
`else
        wait_res("t3", 2, 32'hFFFE_0001);
        ack("t3", 32'hFFFE_0001);
`endif

        accept("rs", 16'h1234, 16'h4321);
        in_rdy = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_rdy", {31'd0, res_rdy}, 32'd0);
        check("rs_busy", {31'd0, busy}, 32'd0);
        check("rs_res", res, 32'd0);

        accept("t5", 16'h0300, 16'h0100);
        wait_res("t5", 0, 32'h0003_0000);
        ack("t5", 32'h0003_0000);

        accept("t4", 16'h0000, 16'h1234);
        wait_res("t4", 0, 32'h0000_0000);

        {a_int, a_dec} = 16'h0300;
        {b_int, b_dec} = 16'h0200;
        res_ack = 1'b1;
        in_rdy  = 1'b1;
        tick();
        res_ack = 1'b0;
        check("t6_ack_rdy", {31'd0, res_rdy}, 32'd0);
        check("t6_ack_busy", {31'd0, busy}, 32'd0);
        tick();
        check("t6_acc_busy", {31'd0, busy}, 32'd1);
        wait_res("t6", 0, 32'h0006_0000);
        ack("t6", 32'h0006_0000);

`ifdef FXP_MUL_SIGNED_EN
        accept("s1", 16'hFF00, 16'h0200);
        wait_res("s1", 0, 32'hFFFE_0000);
        ack("s1", 32'hFFFE_0000);

        accept("s2", 16'h8000, 16'h8000);
        wait_res("s2", 0, 32'h4000_0000);
        ack("s2", 32'h4000_0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
